// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter shared between instruction fetch and data load/store.
// Fixed priority in IDLE: store, then load, then fetch. Every access ends in a
// one-cycle DONE state carrying the ready pulse for the granted owner.
module mem_arbiter #(
  parameter int unsigned WR_PULSE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_data,
  output logic        if_ready,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_ready,
  output logic        stall_if,
  output logic        stall_mem,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  typedef enum logic [2:0] {
    IDLE, RD_I, RD_M, WR_SETUP, WR_PULSE, WR_HOLD, DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic        owner_mem_q;
  logic [15:0] if_data_q;
  logic [15:0] mem_rdata_q;

  // Arbitration, transaction sequencing and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_mem_q <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_wr) begin
            state_q     <= WR_SETUP;
            addr_q      <= mem_addr;
            wdata_q     <= mem_wdata;
            owner_mem_q <= 1'b1;
          end else if (mem_rd) begin
            state_q     <= RD_M;
            addr_q      <= mem_addr;
            owner_mem_q <= 1'b1;
          end else if (if_req) begin
            state_q     <= RD_I;
            addr_q      <= if_addr;
            owner_mem_q <= 1'b0;
          end
        end
        RD_I: begin
          if_data_q <= sram_din;
          state_q   <= DONE;
        end
        RD_M: begin
          mem_rdata_q <= sram_din;
          state_q     <= DONE;
        end
        WR_SETUP: begin
          cnt_q   <= 2'(WR_PULSE_CYCLES - 1);
          state_q <= WR_PULSE;
        end
        WR_PULSE: begin
          if (cnt_q == '0) state_q <= WR_HOLD;
          else             cnt_q   <= cnt_q - 2'd1;
        end
        WR_HOLD: state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // SRAM strobes decoded from the registered state only.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_drive = 1'b0;
    case (state_q)
      RD_I, RD_M: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
      end
      WR_SETUP, WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
      end
      WR_PULSE: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        sram_we_n  = 1'b0;
      end
      default: ;
    endcase
  end

  assign sram_addr = addr_q;
  assign sram_dout = wdata_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign if_ready  = (state_q == DONE) && !owner_mem_q;
  assign mem_ready = (state_q == DONE) &&  owner_mem_q;
  assign stall_if  = if_req && !if_ready;
  assign stall_mem = (mem_rd || mem_wr) && !mem_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed checks of mem_arbiter with WR_PULSE_CYCLES=1 and =3, each with its own SRAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;

  logic        if_req, mem_rd, mem_wr;
  logic [15:0] if_addr, mem_addr, mem_wdata;
  logic [15:0] if_data, mem_rdata, sram_addr, sram_dout, sram_din;
  logic        if_ready, mem_ready, stall_if, stall_mem;
  logic        sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

  logic        if_req3, mem_rd3, mem_wr3;
  logic [15:0] if_addr3, mem_addr3, mem_wdata3;
  logic [15:0] if_data3, mem_rdata3, sram_addr3, sram_dout3, sram_din3;
  logic        if_ready3, mem_ready3, stall_if3, stall_mem3;
  logic        sram_drive3, sram_ce_n3, sram_oe_n3, sram_we_n3;

  logic [15:0] sram  [0:65535];
  logic [15:0] sram3 [0:65535];

  int n_total = 0;
  int n_bad   = 0;
  int viol    = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  mem_arbiter #(.WR_PULSE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_data(if_data3), .if_ready(if_ready3),
    .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .mem_ready(mem_ready3),
    .stall_if(stall_if3), .stall_mem(stall_mem3),
    .sram_addr(sram_addr3), .sram_dout(sram_dout3), .sram_din(sram_din3),
    .sram_drive(sram_drive3), .sram_ce_n(sram_ce_n3), .sram_oe_n(sram_oe_n3),
    .sram_we_n(sram_we_n3)
  );

  // SRAM models: asynchronous read, write sampled while we_n is low.
  assign sram_din  = sram[sram_addr];
  assign sram_din3 = sram3[sram_addr3];

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)   sram[sram_addr]   = sram_dout;
    if (!sram_ce_n3 && !sram_we_n3) sram3[sram_addr3] = sram_dout3;
  end

  // Bus contention watch: drive and read enable must never overlap.
  always @(negedge clk) begin
    if (sram_drive && !sram_oe_n)   viol++;
    if (sram_drive3 && !sram_oe_n3) viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  int we_low, oe_low, rdy_cyc, first_low, last_low;

  initial begin
    rst = 1'b1;
    if_req = 0; mem_rd = 0; mem_wr = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
    if_req3 = 0; mem_rd3 = 0; mem_wr3 = 0; if_addr3 = '0; mem_addr3 = '0; mem_wdata3 = '0;
    for (int i = 0; i < 65536; i++) begin
      sram[i]  = 16'h0;
      sram3[i] = 16'h0;
    end
    sram[16'h0004] = 16'h4A21;
    sram[16'h0010] = 16'hBEEF;
    sram[16'h0020] = 16'h1111;
    sram[16'h0030] = 16'hAAAA;

    // Reset state
    tick(); tick();
    check("rst_if_ready", {31'b0, if_ready}, 32'd0);
    check("rst_mem_ready", {31'b0, mem_ready}, 32'd0);
    check("rst_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'hE);
    check("rst_addr", {16'b0, sram_addr}, 32'h0);
    check("rst_dout", {16'b0, sram_dout}, 32'h0);
    rst = 1'b0;
    tick();

    // Instruction fetch from 0x0004
    if_req = 1; if_addr = 16'h0004;
    #1;
    check("if_c0_stall", {31'b0, stall_if}, 32'd1);
    tick();
    if_addr = 16'h0020;
    check("if_c1_addr", {16'b0, sram_addr}, 32'h0004);
    check("if_c1_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'h2);
    check("if_c1_stall", {31'b0, stall_if}, 32'd1);
    tick();
    check("if_c2_ready", {31'b0, if_ready}, 32'd1);
    check("if_c2_data", {16'b0, if_data}, 32'h4A21);
    check("if_c2_stall", {31'b0, stall_if}, 32'd0);
    check("if_c2_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'hE);
    if_req = 0;
    tick();
    check("if_c3_ready", {31'b0, if_ready}, 32'd0);
    check("if_c3_hold", {16'b0, if_data}, 32'h4A21);

    // Store 0x1234 to 0x8000, inputs scrambled after acceptance
    mem_wr = 1; mem_addr = 16'h8000; mem_wdata = 16'h1234;
    #1;
    check("wr_c0_stall", {31'b0, stall_mem}, 32'd1);
    tick();
    mem_addr = 16'h0FFF; mem_wdata = 16'hDEAD;
    check("wr_c1_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'h7);
    check("wr_c1_bus", {sram_addr, sram_dout}, 32'h8000_1234);
    tick();
    check("wr_c2_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'h5);
    check("wr_c2_bus", {sram_addr, sram_dout}, 32'h8000_1234);
    tick();
    check("wr_c3_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'h7);
    check("wr_c3_bus", {sram_addr, sram_dout}, 32'h8000_1234);
    check("wr_c3_ready", {31'b0, mem_ready}, 32'd0);
    tick();
    check("wr_c4_ready", {31'b0, mem_ready}, 32'd1);
    check("wr_c4_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'hE);
    check("wr_c4_ifrdy", {31'b0, if_ready}, 32'd0);
    mem_wr = 0;
    check("wr_sram", {16'b0, sram[16'h8000]}, 32'h1234);
    check("wr_sram_nostray", {16'b0, sram[16'h0FFF]}, 32'h0);
    tick();

    // Contention: load wins, fetch waits behind it
    if_req = 1; if_addr = 16'h0020; mem_rd = 1; mem_addr = 16'h0010;
    tick();
    check("ct_c1_addr", {16'b0, sram_addr}, 32'h0010);
    check("ct_c1_oe", {31'b0, sram_oe_n}, 32'd0);
    check("ct_c1_stall_if", {31'b0, stall_if}, 32'd1);
    tick();
    check("ct_c2_mready", {31'b0, mem_ready}, 32'd1);
    check("ct_c2_mdata", {16'b0, mem_rdata}, 32'hBEEF);
    check("ct_c2_iready", {31'b0, if_ready}, 32'd0);
    check("ct_c2_stall_if", {31'b0, stall_if}, 32'd1);
    mem_rd = 0;
    tick();
    check("ct_c3_idle", {31'b0, sram_ce_n}, 32'd1);
    check("ct_c3_stall_if", {31'b0, stall_if}, 32'd1);
    tick();
    check("ct_c4_addr", {16'b0, sram_addr}, 32'h0020);
    tick();
    check("ct_c5_iready", {31'b0, if_ready}, 32'd1);
    check("ct_c5_idata", {16'b0, if_data}, 32'h1111);
    check("ct_c5_mhold", {16'b0, mem_rdata}, 32'hBEEF);
    if_req = 0;
    tick();

    // Load and store together: only the store happens
    mem_rd = 1; mem_wr = 1; mem_addr = 16'h0030; mem_wdata = 16'h5555;
    we_low = 0; oe_low = 0; rdy_cyc = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (mem_ready) begin
        rdy_cyc = c; mem_rd = 0; mem_wr = 0;
      end
    end
    check("rw_oe_low", oe_low, 32'd0);
    check("rw_we_low", we_low, 32'd1);
    check("rw_ready_cyc", rdy_cyc, 32'd4);
    check("rw_sram", {16'b0, sram[16'h0030]}, 32'h5555);
    check("rw_rdata_hold", {16'b0, mem_rdata}, 32'hBEEF);

    // Reset in the middle of the write pulse
    mem_wr = 1; mem_addr = 16'h0040; mem_wdata = 16'h7777;
    tick();
    tick();
    check("ab_c2_we", {31'b0, sram_we_n}, 32'd0);
    rst = 1;
    tick();
    check("ab_ctl", {28'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_drive}, 32'hE);
    check("ab_ready", {31'b0, mem_ready}, 32'd0);
    check("ab_rdata_clr", {16'b0, mem_rdata}, 32'h0);
    check("ab_idata_clr", {16'b0, if_data}, 32'h0);
    rst = 0; mem_wr = 0;
    rdy_cyc = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_ready) rdy_cyc++;
    end
    check("ab_no_ready", rdy_cyc, 32'd0);

    // Three-cycle write pulse
    mem_wr3 = 1; mem_addr3 = 16'h9000; mem_wdata3 = 16'hCAFE;
    we_low = 0; rdy_cyc = -1; first_low = -1; last_low = -1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!sram_we_n3) begin
        we_low++;
        if (first_low < 0) first_low = c;
        last_low = c;
        check("p3_bus", {sram_addr3, sram_dout3}, 32'h9000_CAFE);
      end
      if (mem_ready3) begin
        rdy_cyc = c; mem_wr3 = 0;
      end
    end
    check("p3_we_low", we_low, 32'd3);
    check("p3_first_low", first_low, 32'd2);
    check("p3_last_low", last_low, 32'd4);
    check("p3_ready_cyc", rdy_cyc, 32'd6);
    check("p3_sram", {16'b0, sram3[16'h9000]}, 32'hCAFE);

    check("bus_overlap", viol, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one parameter, WR_PULSE_CYCLES, with default 1 (legal range 1-4), which sets the number of cycles sram_we_n is held low per write.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  instruction fetch request, held until if_ready.
- if_addr  in  16  fetch address.
- if_data  out  16  fetched instruction, valid while if_ready=1.
- if_ready  out  1  fetch complete, one-cycle pulse.
- mem_rd  in  1  data load request, held until mem_ready.
- mem_wr  in  1  data store request, held until mem_ready.
- mem_addr  in  16  load/store address.
- mem_wdata  in  16  store data.
- mem_rdata  out  16  load data, valid while mem_ready=1.
- mem_ready  out  1  load/store complete, one-cycle pulse.
- stall_if  out  1  hold PC and the IF/ID register.
- stall_mem  out  1  hold the whole pipeline behind MEM.
- sram_addr  out  16  SRAM address.
- sram_dout  out  16  data driven onto the SRAM bus.
- sram_din  in  16  data read from the SRAM bus.
- sram_drive  out  1  tri-state enable for sram_dout.
- sram_ce_n  out  1  SRAM chip enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low.

Function
REQ-003 The FSM SHALL have states IDLE, RD_I, RD_M, WR_SETUP, WR_PULSE, WR_HOLD and DONE; SRAM controls SHALL be Moore outputs decoded from registered state.
REQ-004 In IDLE, the block SHALL select in fixed priority: mem_wr goes to WR_SETUP, else mem_rd goes to RD_M, else if_req goes to RD_I, else it stays in IDLE.
REQ-005 On leaving IDLE, the block SHALL latch the granted address (plus mem_wdata for writes) and the grant owner; later input changes SHALL NOT affect the transaction in flight.
REQ-006 When mem_rd and mem_wr are both 1, the block SHALL perform the write only.
REQ-007 In RD_I and RD_M, the block SHALL drive sram_addr to the latched address with ce_n=0, oe_n=0, we_n=1 and drive=0, and SHALL capture sram_din into the owner's data register at the closing edge; the next state is DONE.
REQ-008 In WR_SETUP, the block SHALL drive the latched address and data with ce_n=0, we_n=1, oe_n=1 and drive=1.
REQ-009 In WR_PULSE, the block SHALL additionally set we_n=0 and remain there for exactly WR_PULSE_CYCLES cycles, using a counter reloaded on entry.
REQ-010 WR_HOLD SHALL match WR_SETUP, and its next state is DONE.
REQ-011 Address and data SHALL be stable across the whole write, including one cycle before and one cycle after we_n=0.
REQ-012 In DONE, the block SHALL assert if_ready or mem_ready (owner only) for exactly one cycle with all SRAM controls inactive; the next state is IDLE, and no request is sampled in DONE.
REQ-013 Latency from request acceptance SHALL be: reads ready in the 2nd following cycle (3 cycles per access); writes ready in the (3+WR_PULSE_CYCLES)th following cycle.
REQ-014 The block SHALL drive stall_if = if_req AND NOT if_ready, and stall_mem = (mem_rd OR mem_wr) AND NOT mem_ready, both combinational.
REQ-015 if_data and mem_rdata SHALL hold their last captured values outside ready cycles.
REQ-016 An IF request pending behind a MEM request SHALL wait, with stall_if held, until the MEM transaction's DONE, and is then served from the next IDLE if mem_rd and mem_wr are both 0.
REQ-017 sram_drive and sram_oe_n=0 SHALL never be active in the same cycle.

Reset
REQ-018 At a clock edge with rst=1, the block SHALL enter IDLE from any state, aborting any transaction, and clear the pulse counter, if_data, mem_rdata and the grant owner.
REQ-019 After reset, outputs SHALL be: ready outputs 0, sram_ce_n=oe_n=we_n=1, sram_drive=0, and sram_addr and sram_dout 0.
REQ-020 An aborted transaction SHALL produce no ready pulse.

Verification
REQ-021 IF read: SRAM[0x0004]=0x4A21 and if_req=1 at cycle 0 -> RD_I at cycle 1 (addr 0x0004, oe_n=0), if_ready=1 with if_data=0x4A21 at cycle 2, and stall_if=1 during cycles 0-1.
REQ-022 Store, WR_PULSE_CYCLES=1: mem_wr=1, addr 0x8000, data 0x1234 -> we_n=0 in cycle 2 only, drive=1 in cycles 1-3, mem_ready at cycle 4, and SRAM[0x8000]=0x1234.
REQ-023 Contention: if_req and mem_rd both 1 at cycle 0 -> MEM is served, mem_ready at cycle 2, IDLE at cycle 3, IF is granted with mem_rd dropped, and if_ready at cycle 5.
REQ-024 mem_rd=mem_wr=1 -> a write sequence only, with oe_n never 0.
REQ-025 rst=1 during WR_PULSE -> the next cycle has we_n=1, drive=0, state IDLE, and no mem_ready pulse.
REQ-026 WR_PULSE_CYCLES=3 -> we_n is low for exactly 3 consecutive cycles and mem_ready comes at cycle 6.
